// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch sequencer.
// Contents:
//   state_e      sequencer state (IDLE/FETCH/DONE)
//   COND_*       condition selects for cccc[3:1]
//   FLAG_*       bit positions of C, V, Z and N inside the cvzn vector
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [2:0] COND_Z      = 3'd0;
    localparam logic [2:0] COND_C      = 3'd1;
    localparam logic [2:0] COND_N      = 3'd2;
    localparam logic [2:0] COND_V      = 3'd3;
    localparam logic [2:0] COND_HI     = 3'd4;
    localparam logic [2:0] COND_GE     = 3'd5;
    localparam logic [2:0] COND_GT     = 3'd6;
    localparam logic [2:0] COND_ALWAYS = 3'd7;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition evaluator.
// Ports:
//   cccc  in  4  condition code; [3:1] selects the test, [0] inverts it
//   cvzn  in  4  flags {C,V,Z,N}
//   go    out 1  branch decision
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cccc,
    input  logic [3:0] cvzn,
    output logic       go
);

    logic c, v, z, n, sel;

    assign c = cvzn[FLAG_C];
    assign v = cvzn[FLAG_V];
    assign z = cvzn[FLAG_Z];
    assign n = cvzn[FLAG_N];

    always_comb begin
        sel = 1'b1;
        case (cccc[3:1])
            COND_Z:      sel = z;
            COND_C:      sel = c;
            COND_N:      sel = n;
            COND_V:      sel = v;
            COND_HI:     sel = c & ~z;
            COND_GE:     sel = ~(n ^ v);
            COND_GT:     sel = ~z & ~(n ^ v);
            COND_ALWAYS: sel = 1'b1;
            default:     sel = 1'b1;
        endcase
    end

    // The low bit turns every test into its complement (1110 always, 1111 never).
    assign go = sel ^ cccc[0];

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: multi-cycle conditional branch sequencer between the
// decoder FSM and the PC register. Snapshots condition and flags on start,
// fetches the operand byte, then issues a single-cycle PC load.
// Ports:
//   clk        in   1       clock, rising edge
//   rst_n      in   1       synchronous active-low reset
//   start      in   1       branch issue strobe, ignored while busy
//   cccc       in   4       condition code
//   cvzn       in   4       flags {C,V,Z,N}
//   pc_in      in   ADDR_W  operand byte address
//   mem_req    out  1       operand read request
//   mem_addr   out  ADDR_W  operand read address
//   mem_ack    in   1       read data valid
//   mem_rdata  in   DATA_W  operand byte
//   pc_load    out  1       one-cycle PC write strobe
//   pc_next    out  ADDR_W  new PC, valid with pc_load
//   taken      out  1       branch decision, valid with pc_load
//   busy       out  1       high outside IDLE
// Build option: BRANCH_REL_EN makes the operand a signed displacement
// relative to the fall-through address instead of an absolute target.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        cccc,
    input  logic [3:0]        cvzn,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              taken,
    output logic              busy
);

    state_e            state;
    logic [3:0]        cc_q;
    logic [3:0]        fl_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] op_q;
    logic              go;
    logic [ADDR_W-1:0] fall;
    logic [ADDR_W-1:0] target;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cc_q  <= '0;
            fl_q  <= '0;
            pc_q  <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= FETCH;
                    cc_q  <= cccc;
                    fl_q  <= cvzn;
                    pc_q  <= pc_in;
                end
                FETCH: if (mem_ack) begin
                    state <= DONE;
                    op_q  <= mem_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

    branch_cond_eval u_cond (
        .cccc (cc_q),
        .cvzn (fl_q),
        .go   (go)
    );

    assign fall = pc_q + ADDR_W'(1);

`ifdef BRANCH_REL_EN
    // Signed cast before widening gives the sign extension of the displacement.
    assign target = fall + ADDR_W'($signed(op_q));
`else
    assign target = ADDR_W'(op_q);
`endif

    assign busy     = state != IDLE;
    assign mem_req  = state == FETCH;
    assign mem_addr = pc_q;
    assign pc_load  = state == DONE;
    assign taken    = pc_load & go;
    // Forced to zero outside DONE so the bus is quiet after reset.
    assign pc_next  = pc_load ? (go ? target : fall) : '0;

endmodule
